// File: rtl/pipe_pkg.sv
// Shared constants for pipeline stage registers.
// Count width and default control/reset settings.
package pipe_pkg;

   localparam int          CNT_W         = 2;
   localparam int          CTRL_W_DEF    = 8;
   localparam int unsigned RESET_VAL_DEF = 0;

endpackage

// File: rtl/pipe_skid_buf.sv
// Second (skid) entry of a pipeline stage register.
// Catches a beat that arrives while the main entry is stalled.
module pipe_skid_buf
   import pipe_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic [WIDTH-1:0] dout
);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         full <= 1'b0;
         dout <= '0;
      end else begin
         if (flush_i)
            full <= 1'b0;
         else if (push)
            full <= 1'b1;
         else if (pop)
            full <= 1'b0;
         if (push && !flush_i)
            dout <= din;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with bubble and flush squash.
// Define PIPE_STAGE_SKID_EN for a two-entry skid variant with registered ready_o.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int               WIDTH      = 32,
   parameter int               CTRL_WIDTH = CTRL_W_DEF,
   parameter logic [WIDTH-1:0] RESET_VAL  = WIDTH'(RESET_VAL_DEF)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] data_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] data_o,
   output logic [CNT_W-1:0] count_o
);

   localparam logic [CTRL_WIDTH-1:0] CTRL_ZERO = '0;

   logic             valid_q;
   logic             valid_d;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;
   logic [WIDTH-1:0] bubble;
   logic             accept;
   logic             deliver;

   assign accept  = valid_i & ready_o;
   assign deliver = valid_q & ready_i;
   assign bubble  = {data_q[WIDTH-1:CTRL_WIDTH], CTRL_ZERO};
   assign valid_o = valid_q;
   assign data_o  = data_q;

`ifdef PIPE_STAGE_SKID_EN
   logic             skid_full;
   logic             skid_push;
   logic             skid_pop;
   logic             skid_nxt;
   logic [WIDTH-1:0] skid_data;
   logic             ready_q;

   assign skid_push = accept & valid_q & ~ready_i;
   assign skid_pop  = deliver & skid_full;
   assign skid_nxt  = ~flush_i & (skid_push | (skid_full & ~skid_pop));
   assign ready_o   = ready_q;
   assign count_o   = CNT_W'(valid_q) + CNT_W'(skid_full);

   pipe_skid_buf #(
      .WIDTH(WIDTH)
   ) u_skid (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .flush_i(flush_i),
      .push   (skid_push),
      .pop    (skid_pop),
      .din    (data_i),
      .full   (skid_full),
      .dout   (skid_data)
   );

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (flush_i) begin
         valid_d = 1'b0;
         data_d  = bubble;
      end else if (skid_pop) begin
         valid_d = 1'b1;
         data_d  = skid_data;
      end else if (accept && (!valid_q || ready_i)) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (deliver) begin
         valid_d = 1'b0;
         data_d  = bubble;
      end
   end

   // ready_o is registered so ready_i never reaches it combinationally
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         ready_q <= 1'b0;
      else
         ready_q <= ~(valid_d & skid_nxt);
   end
`else
   logic live_q;

   assign ready_o = live_q & (~valid_q | ready_i);
   assign count_o = {1'b0, valid_q};

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (flush_i) begin
         valid_d = 1'b0;
         data_d  = bubble;
      end else if (accept) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (deliver) begin
         valid_d = 1'b0;
         data_d  = bubble;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         live_q <= 1'b0;
      else
         live_q <= 1'b1;
   end
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         data_q  <= {RESET_VAL[WIDTH-1:CTRL_WIDTH], CTRL_ZERO};
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg against a queue-based model.
// Covers reset, streaming, stall, bubble, flush, mid-stall reset and random traffic.
module tb_pipe_stage_reg;

   localparam int W = 32;
`ifdef PIPE_STAGE_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   logic         clk_i = 1'b0;
   logic         rst_ni = 1'b0;
   logic         flush_i = 1'b0;
   logic         valid_i = 1'b0;
   logic         ready_i = 1'b0;
   logic [W-1:0] data_i = '0;
   logic         ready_o;
   logic         valid_o;
   logic [W-1:0] data_o;
   logic [1:0]   count_o;

   pipe_stage_reg #(
      .WIDTH(W)
   ) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .flush_i(flush_i),
      .valid_i(valid_i),
      .ready_o(ready_o),
      .data_i (data_i),
      .valid_o(valid_o),
      .ready_i(ready_i),
      .data_o (data_o),
      .count_o(count_o)
   );

   always #5 clk_i = ~clk_i;

   // model: held beats in order, last visible datapath bits, out-of-reset flag
   logic [W-1:0] mq[$];
   logic [W-9:0] last_dp;
   bit           live;
   int           n_cmp;
   int           n_bad;
   logic         obs_rdy;
   logic         exp_rdy;

   function automatic logic m_ready();
      if (!live)
         return 1'b0;
      if (SKID)
         return mq.size() < 2;
      return mq.size() == 0 || ready_i;
   endfunction

   function automatic logic [W-1:0] m_data();
      return mq.size() != 0 ? mq[0] : {last_dp, 8'h00};
   endfunction

   function automatic logic [1:0] m_count();
      return 2'(mq.size());
   endfunction

   function automatic logic m_valid();
      return mq.size() != 0;
   endfunction

   task automatic m_reset();
      mq.delete();
      last_dp = '0;
      live = 1'b0;
   endtask

   // drive one cycle, sample ready_o before the edge, advance model at the edge
   task automatic tick(input logic v, input logic [W-1:0] d,
                       input logic r, input logic f);
      logic acc;
      valid_i = v;
      data_i  = d;
      ready_i = r;
      flush_i = f;
      #1;
      obs_rdy = ready_o;
      exp_rdy = m_ready();
      acc = v && exp_rdy;
      @(posedge clk_i);
      if (rst_ni) begin
         live = 1'b1;
         if (f) begin
            mq.delete();
         end else begin
            if (mq.size() != 0 && r)
               void'(mq.pop_front());
            if (acc)
               mq.push_back(d);
         end
         if (mq.size() != 0)
            last_dp = mq[0][W-1:8];
      end
      #1;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      m_reset();
      #2;
      n_cmp++;
      if (valid_o !== 1'b0 || count_o !== 2'd0 || data_o !== '0) begin
         n_bad++;
         $display("FAIL reset_out valid=%b count=%0d data=%h want 0/0/0",
                  valid_o, count_o, data_o);
      end
      n_cmp++;
      if (ready_o !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_ready got=%b want=0", ready_o);
      end
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i);
      live = 1'b1;
      #1;
      n_cmp++;
      if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_release ready=%b valid=%b want 1/0",
                  ready_o, valid_o);
      end
   endtask

   task automatic test_stream();
      logic [W-1:0] s [3];
      s[0] = 32'h11;
      s[1] = 32'h22;
      s[2] = 32'h33;
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, s[i], 1'b1, 1'b0);
         n_cmp++;
         if (obs_rdy !== 1'b1 || data_o !== s[i] || valid_o !== 1'b1 ||
             count_o !== 2'd1) begin
            n_bad++;
            $display("FAIL stream[%0d] rdy=%b data=%h valid=%b count=%0d want 1/%h/1/1",
                     i, obs_rdy, data_o, valid_o, count_o, s[i]);
         end
      end
      tick(1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
      n_cmp++;
      if (valid_o !== 1'b0 || data_o !== 32'h0 || count_o !== 2'd0) begin
         n_bad++;
         $display("FAIL stream_drain valid=%b data=%h count=%0d want 0/0/0",
                  valid_o, data_o, count_o);
      end
   endtask

   task automatic test_stall();
      tick(1'b1, 32'hA5A5_A5FF, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, $urandom, 1'b0, 1'b0);
         n_cmp++;
         if (data_o !== 32'hA5A5_A5FF || valid_o !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_hold[%0d] data=%h valid=%b want a5a5a5ff/1",
                     i, data_o, valid_o);
         end
         n_cmp++;
         if (ready_o !== SKID) begin
            n_bad++;
            $display("FAIL stall_ready[%0d] got=%b want=%b", i, ready_o, SKID);
         end
      end
      tick(1'b1, 32'h0000_0101, 1'b0, 1'b0);
      n_cmp++;
      if (count_o !== m_count() || data_o !== 32'hA5A5_A5FF) begin
         n_bad++;
         $display("FAIL stall_skid count=%0d data=%h want %0d/a5a5a5ff",
                  count_o, data_o, m_count());
      end
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, $urandom, 1'b1, 1'b0);
         n_cmp++;
         if (valid_o !== m_valid() || data_o !== m_data() ||
             count_o !== m_count() || obs_rdy !== exp_rdy) begin
            n_bad++;
            $display("FAIL stall_drain[%0d] v=%b d=%h c=%0d r=%b want %b/%h/%0d/%b",
                     i, valid_o, data_o, count_o, obs_rdy,
                     m_valid(), m_data(), m_count(), exp_rdy);
         end
      end
   endtask

   task automatic test_bubble();
      tick(1'b1, 32'h1234_56FF, 1'b1, 1'b0);
      tick(1'b0, $urandom, 1'b1, 1'b0);
      n_cmp++;
      if (valid_o !== 1'b0 || data_o !== 32'h1234_5600) begin
         n_bad++;
         $display("FAIL bubble valid=%b data=%h want 0/12345600",
                  valid_o, data_o);
      end
   endtask

   task automatic test_flush();
      tick(1'b1, 32'h44, 1'b1, 1'b0);
      tick(1'b0, $urandom, 1'b0, 1'b0);
      tick(1'b1, 32'h55, 1'b0, 1'b1);
      n_cmp++;
      if (valid_o !== 1'b0 || count_o !== 2'd0 || data_o !== 32'h0) begin
         n_bad++;
         $display("FAIL flush valid=%b count=%0d data=%h want 0/0/0",
                  valid_o, count_o, data_o);
      end
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, $urandom, 1'b1, 1'b0);
         n_cmp++;
         if (valid_o !== 1'b0 || data_o === 32'h55) begin
            n_bad++;
            $display("FAIL flush_after[%0d] valid=%b data=%h want valid 0",
                     i, valid_o, data_o);
         end
      end
   endtask

   task automatic test_reset_mid();
      tick(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
      tick(1'b0, $urandom, 1'b0, 1'b0);
      #2;
      rst_ni = 1'b0;
      m_reset();
      #1;
      n_cmp++;
      if (valid_o !== 1'b0 || count_o !== 2'd0 || data_o !== 32'h0 ||
          ready_o !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_mid valid=%b count=%0d data=%h ready=%b want 0/0/0/0",
                  valid_o, count_o, data_o, ready_o);
      end
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i);
      live = 1'b1;
      #1;
      n_cmp++;
      if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_mid_release ready=%b valid=%b want 1/0",
                  ready_o, valid_o);
      end
      tick(1'b0, $urandom, 1'b1, 1'b0);
      n_cmp++;
      if (valid_o !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_mid_nobeat valid=%b want 0", valid_o);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         tick(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0,
              ($urandom % 20) == 0);
         n_cmp++;
         if (obs_rdy !== exp_rdy) begin
            n_bad++;
            $display("FAIL rand_ready[%0d] got=%b want=%b", i, obs_rdy, exp_rdy);
         end
         n_cmp++;
         if (valid_o !== m_valid() || data_o !== m_data() ||
             count_o !== m_count()) begin
            n_bad++;
            $display("FAIL rand_out[%0d] v=%b d=%h c=%0d want %b/%h/%0d",
                     i, valid_o, data_o, count_o, m_valid(), m_data(), m_count());
         end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      m_reset();
      test_reset();
      test_stream();
      test_stall();
      test_bubble();
      test_flush();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32: total payload bits per beat.
REQ-002 SHALL have parameter CTRL_WIDTH, default 8: payload bits [CTRL_WIDTH-1:0] are control fields (RegWrite, MemWrite, ...) and are zeroed on bubble/flush.
REQ-003 SHALL have parameter RESET_VAL, default 0: datapath bits [WIDTH-1:CTRL_WIDTH] of data_o at reset.
REQ-004 SHALL have port clk_i  input  1  single clock, rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port flush_i  input  1  synchronous squash of stage contents.
REQ-007 SHALL have port valid_i  input  1  upstream beat valid.
REQ-008 SHALL have port ready_o  output  1  stage can accept a beat.
REQ-009 SHALL have port data_i  input  WIDTH  upstream payload.
REQ-010 SHALL have port valid_o  output  1  downstream beat valid.
REQ-011 SHALL have port ready_i  input  1  downstream accepts (0 = stall).
REQ-012 SHALL have port data_o  output  WIDTH  registered payload.
REQ-013 SHALL have port count_o  output  2  entries held (0..1, or 0..2 with skid).

Function
REQ-014 SHALL accept a beat in a cycle iff valid_i && ready_o; SHALL deliver iff valid_o && ready_i.
REQ-015 SHALL present an accepted beat on data_o/valid_o exactly 1 cycle after acceptance (registered outputs, no combinational data_i->data_o path).
REQ-016 SHALL sustain 1 beat/cycle when ready_i is held 1.
REQ-017 SHALL hold data_o and valid_o stable while valid_o && !ready_i (stall); no beat lost or duplicated.
REQ-018 Base mode: SHALL drive ready_o = !valid_o || ready_i (single entry; simultaneous deliver+accept allowed).
REQ-019 SHALL, when output drains with no new beat (bubble), drive valid_o=0 and data_o[CTRL_WIDTH-1:0]=0; datapath bits hold last value.
REQ-020 SHALL, on flush_i=1 at a clock edge, set valid_o=0, count_o=0, control bits 0; beat offered the same cycle SHALL be discarded; flush beats stall and accept.
REQ-021 SHALL keep count_o equal to the number of held beats, updated same edge as valid_o.
REQ-022 SHALL ignore data_i when valid_i=0 (no register update).

Reset
REQ-023 SHALL, while rst_ni=0, asynchronously force valid_o=0, count_o=0, data_o={datapath=RESET_VAL, ctrl=0}, skid entry empty.
REQ-024 SHALL drive ready_o=0 during reset and 1 from the first edge after deassertion.
REQ-025 Reset mid-transfer SHALL drop all held beats; no beat emitted after release until a new accept.

Configuration
REQ-026 Macro PIPE_STAGE_SKID_EN defined: SHALL add a second (skid) entry; ready_o SHALL be a register equal to (count_o<2), breaking ready_i->ready_o path; beat arriving during stall SHALL go to skid and be delivered in order after the main entry; count_o reaches 2.
REQ-027 Macro undefined: SHALL implement REQ-018 single entry; count_o[1]=0 constant.
REQ-028 Flush with skid SHALL clear both entries.

Structure
REQ-029 Shared package pipe_pkg SHALL hold count width constant and default CTRL_WIDTH/RESET_VAL.
REQ-030 Skid storage SHALL be sub-module pipe_skid_buf, instantiated only under PIPE_STAGE_SKID_EN.
REQ-031 Existing IF/ID, ID/EX, EX/MEM, MEM/WB registers SHALL be replaceable by instances with WIDTH set to their concatenated field widths.

Verification
REQ-032 Stream 0x11,0x22,0x33 with ready_i=1 -> data_o 0x11,0x22,0x33 on consecutive cycles, 1-cycle latency, count_o=1.
REQ-033 Accept 0xA5A5_A5FF, ready_i=0 for 3 cycles -> data_o stays 0xA5A5_A5FF, valid_o=1; base ready_o=0; skid build count_o=2 after next beat 0x0000_0101, then drains in order.
REQ-034 valid_o=1 with 0x1234_56FF, ready_i=1, valid_i=0 -> next cycle valid_o=0, data_o=0x1234_5600.
REQ-035 flush_i=1 same cycle as valid_i=1 data 0x55 while holding 0x44 -> next cycle valid_o=0, count_o=0; 0x55 never appears.
REQ-036 rst_ni low mid-stall holding 0xDEAD_BEEF -> valid_o=0 immediately (before clock edge), data_o=RESET_VAL/ctrl 0; after release ready_o=1 next edge.
